booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Sequential radix-2 Booth multiplier for the FIR filter datapath: multiplies an 8-bit signed coefficient by an 8-bit signed sample over 8 iterations and returns a 16-bit signed product. It is the consumer of the 9-bit add/subtract operand selection in the Booth datapath. It owns the accumulator, the shift register, the iteration counter and the start/done handshake. Its product feeds the FIR accumulation stage.

## Interface
- WIDTH, 8, operand width; accumulator and operand-select path are WIDTH+1 (9) bits. Only 8 is verified.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; honoured only in IDLE or DONE.
- a  in  8  multiplicand (signed, two's complement); sampled on the accepting edge.
- b  in  8  multiplier (signed); sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product is valid from this cycle onward.
- product  out  16  signed result; holds until the next done.

## Operation
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE, start=1: load the registers, clear cnt, go to RUN.
  - M = sign-extended a (9 bits).
  - acc = 0 (9 bits).
  - Q = b.
  - q_1 = 0.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle, Booth pair {Q[0], q_1}:
  - 01: acc_n = acc + M.
  - 10: acc_n = acc + ~M + 1. The operand is selected by a 9-bit 2:1 mux with select = Q[0]; carry-in = Q[0].
  - 00 or 11: acc_n = acc.
  - Then arithmetic right shift of {acc_n, Q, q_1}: acc <= {acc_n[8], acc_n[8:1]}, Q <= {acc_n[0], Q[7:1]}, q_1 <= Q[0].
  - cnt increments. After the 8th RUN cycle (cnt==7), go to DONE.
- DONE:
  - product <= {acc[7:0], Q}; done=1.
  - start=1: accept new operands and go to RUN (back-to-back).
  - start=0: go to IDLE.
- Width rule: all adds are 9-bit modulo 2^9. The 9-bit accumulator covers the subtraction of M=-128 without overflow. After 8 iterations acc[8]==acc[7], so dropping acc[8] is lossless. Full range is exact, including -128*-128 = 16384.
- start in RUN is ignored: no queuing, and operands are not resampled.
- a and b are don't-care outside the accepting edge.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, product=0.
  - acc=0, Q=0, q_1=0, cnt=0, M=0.
- Latency: start accepted at edge k. busy=1 for cycles k+1..k+8. done=1 and product valid in cycle k+9.
- Throughput: one product per 9 cycles when start is held or re-asserted in the DONE cycle.
- done is high for exactly one cycle per accepted start. busy and done are never high together.
- product changes only on entry to DONE, or to 0 on reset.
- Reset mid-RUN: at the next edge everything returns to reset values, no done is produced, and the aborted result is discarded.
- rst and start high in the same cycle: reset wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package booth_pkg holds:
  - WIDTH = 8 and ACC_W = WIDTH+1.
  - State typedef with IDLE/RUN/DONE encodings.
  - Booth pair constants (ADD=2'b01, SUB=2'b10).
- Sub-module booth_addsub_9b:
  - Combinational 9-bit add/subtract: acc ± M.
  - Built on the team's existing 9-bit 2:1 mux cell, selecting M or ~M, plus a carry-in.
  - It is instantiated once. The top level holds the FSM, the counter and the shift registers.

## Test plan
- Reset, then a=3, b=5, start for 1 cycle -> busy for 8 cycles, done pulse at k+9, product=15, back to IDLE.
- a=-128, b=-128 -> product=16384. a=-128, b=127 -> product=-16256. a=127, b=-1 -> product=-127.
- a=0, b=-77 and a=-77, b=0 -> product=0; done still at k+9.
- start pulsed in RUN cycle 4 with different operands -> ignored; the original product is returned and only one done pulse occurs.
- start held high continuously with operands changed at each DONE cycle -> a done every 9 cycles, each product matching its own sampled operands.
- rst asserted in RUN cycle 5 -> no done, and product=0, busy=0 next cycle. A subsequent a=-3, b=7 returns -21.
- Randomized check of 1000 operand pairs against a signed reference product.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared widths, FSM encoding and Booth pair codes for the sequential Booth multiplier.
package booth_pkg;

  localparam int WIDTH = 8;
  localparam int ACC_W = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/booth_addsub_9b.sv
// Combinational acc +/- M: 2:1 operand mux (M or ~M) with the select doubling as carry-in.
module booth_addsub_9b
  import booth_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] m,
  input  logic                    sub,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] opnd;
  logic signed [ACC_W-1:0] cin;

  always_comb begin
    opnd = sub ? ~m : m;
    cin  = $signed({{(ACC_W-1){1'b0}}, sub});
    // Wraps modulo 2^ACC_W; one guard bit keeps subtracting M=-128 exact.
    sum  = acc + opnd + cin;
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, product after WIDTH steps.
module booth_seq_mult
  import booth_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [WIDTH-1:0]    a,
  input  logic signed [WIDTH-1:0]    b,
  output logic                       busy,
  output logic                       done,
  output logic signed [2*WIDTH-1:0]  product
);

  state_t                  state;
  logic signed [ACC_W-1:0] m;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_n;
  logic        [WIDTH-1:0] q;
  logic                    q_1;
  logic        [CNT_W-1:0] cnt;
  logic        [1:0]       pair;

  booth_addsub_9b u_addsub (
    .acc (acc),
    .m   (m),
    .sub (q[0]),
    .sum (sum)
  );

  always_comb begin
    pair  = {q[0], q_1};
    acc_n = acc;
    if (pair == ADD || pair == SUB) acc_n = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= {a[WIDTH-1], a};
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= {acc_n[ACC_W-1], acc_n[ACC_W-1:1]};
          q   <= {acc_n[0], q[WIDTH-1:1]};
          q_1 <= q[0];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            // Product is taken from the post-shift value so it is valid in the done cycle.
            product <= {acc_n, q[WIDTH-1:1]};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomized bench for booth_seq_mult against a plain signed-multiply model.
module tb_booth_seq_mult;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic               busy;
  logic               done;
  logic signed [15:0] product;

  int total = 0;
  int bad   = 0;

  booth_seq_mult dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic signed [15:0] ref_mul(input int x, input int y);
    ref_mul = 16'(x * y);
  endfunction

  // One multiply from IDLE; optional start pulse with other operands in RUN cycle inj (1..8).
  task automatic do_mult(input int x, input int y, input int inj, input string tag);
    logic signed [15:0] exp;
    exp = ref_mul(x, y);
    @(negedge clk);
    a = 8'(x); b = 8'(y); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      if (i == inj) begin
        start = 1'b1; a = 8'(x + 1); b = 8'(y - 1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_prod"}, 32'(product), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int xs[4];
    int ys[4];
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    rst = 1'b0;

    do_mult(3, 5, 0, "d3x5");
    chk("idle_busy", 32'(busy), 32'd0);
    do_mult(-128, -128, 0, "dmin_min");
    do_mult(-128, 127, 0, "dmin_max");
    do_mult(127, -1, 0, "dmax_m1");
    do_mult(0, -77, 0, "dzero_a");
    do_mult(-77, 0, 0, "dzero_b");
    do_mult(19, -6, 4, "dinject");

    // Start held high: a new product every 9 cycles from the operands present at each DONE cycle.
    xs = '{12, -100, 127, -128};
    ys = '{-9, -100, 127, 1};
    @(negedge clk);
    a = 8'(xs[0]); b = 8'(ys[0]); start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      for (int i = 1; i <= 8; i++) begin
        chk("b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_prod", 32'(product), 32'(ref_mul(xs[k], ys[k])));
      if (k < 3) begin
        a = 8'(xs[k+1]); b = 8'(ys[k+1]);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end", 32'(done), 32'd0);

    // Reset in RUN cycle 5 aborts the multiply.
    a = 8'(50); b = 8'(-3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_prod", 32'(product), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    do_mult(-3, 7, 0, "post_abort");

    // rst and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'(9); b = 8'(9);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      do_mult($signed(8'($urandom)), $signed(8'($urandom)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
